secded_rd_decoder: RTL

SECDED_RD_DECODER -- requirements
Module: secded_rd_decoder

---
 rtl/secded_rd_decoder_if.sv | 41 ++++
 rtl/secded_rd_decoder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/secded_rd_decoder_if.sv
// secded_rd_decoder_if
//   Bus between a memory read port and the SECDED read decoder.
//   master : drives i_valid/i_dout/i_addr/i_clr, observes the decoded result
//   slave  : the decoder; consumes the read word, drives o_* results
//   Widths follow the decoder: i_dout is [ENCODED_WORD+1:1], where the
//   top bit is the overall parity over the Hamming word below it.
interface secded_rd_decoder_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int CNT_WIDTH  = 8
);
    localparam int PARITY_BITS  = $clog2(DATA_WIDTH) + 1;
    localparam int ENCODED_WORD = DATA_WIDTH + PARITY_BITS;

    logic                      i_valid;
    logic [ENCODED_WORD+1:1]   i_dout;
    logic [ADDR_WIDTH-1:0]     i_addr;
    logic                      i_clr;

    logic                      o_valid;
    logic [DATA_WIDTH-1:0]     o_data;
    logic                      o_sec;
    logic                      o_ded;
    logic [PARITY_BITS-1:0]    o_syndrome;
    logic [CNT_WIDTH-1:0]      o_sec_cnt;
    logic [CNT_WIDTH-1:0]      o_ded_cnt;
    logic [ADDR_WIDTH-1:0]     o_ded_addr;
    logic                      o_ded_sticky;

    modport master (
        output i_valid, i_dout, i_addr, i_clr,
        input  o_valid, o_data, o_sec, o_ded, o_syndrome,
               o_sec_cnt, o_ded_cnt, o_ded_addr, o_ded_sticky
    );

    modport slave (
        input  i_valid, i_dout, i_addr, i_clr,
        output o_valid, o_data, o_sec, o_ded, o_syndrome,
               o_sec_cnt, o_ded_cnt, o_ded_addr, o_ded_sticky
    );
endinterface

// File: rtl/secded_rd_decoder.sv
// secded_rd_decoder
//   Hamming SECDED decoder for a memory read path. The incoming word is
//   decoded combinationally, then registered through RD_LATENCY stages.
//   Ports:
//     clk   - rising-edge clock
//     rst_n - asynchronous active-low reset (clears pipeline and outputs)
//     bus   - secded_rd_decoder_if.slave: i_valid/i_dout/i_addr/i_clr in,
//             o_valid/o_data/o_sec/o_ded/o_syndrome and error stats out
//   Build option: define SECDED_ERR_CNT_EN to get saturating SEC/DED
//   counters and first-DED address capture; otherwise those outputs are
//   tied to zero and i_addr/i_clr are ignored.
module secded_rd_decoder #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int RD_LATENCY = 1,
    parameter int CNT_WIDTH  = 8
) (
    input logic                clk,
    input logic                rst_n,
    secded_rd_decoder_if.slave bus
);
    localparam int PARITY_BITS  = $clog2(DATA_WIDTH) + 1;
    localparam int ENCODED_WORD = DATA_WIDTH + PARITY_BITS;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]  data;
        logic                   sec;
        logic                   ded;
        logic [PARITY_BITS-1:0] syn;
    } stage_t;

    // Every power-of-two position in 1..ENCODED_WORD is a check bit; the
    // data bits fill the rest in ascending order (data LSB at position 3).
    function automatic bit is_pow2(int p);
        return (p & (p - 1)) == 0;
    endfunction

    function automatic int data_pos(int idx);
        int n;
        int pos;
        n   = 0;
        pos = 0;
        for (int p = 1; p <= ENCODED_WORD; p++) begin
            if (!is_pow2(p)) begin
                if (n == idx) pos = p;
                n++;
            end
        end
        return pos;
    endfunction

    logic [PARITY_BITS-1:0]  syn;
    logic                    p_all;
    logic [ENCODED_WORD:1]   corr;
    logic [DATA_WIDTH-1:0]   dec_data;
    logic                    dec_sec;
    logic                    dec_ded;
    stage_t                  dec;

    always_comb begin
        syn = '0;
        for (int k = 0; k < PARITY_BITS; k++)
            for (int p = 1; p <= ENCODED_WORD; p++)
                if (((p >> k) & 1) == 1) syn[k] = syn[k] ^ bus.i_dout[p];
    end

    assign p_all = ^bus.i_dout;

    // A nonzero syndrome with odd overall parity is a single error only
    // if it points inside the Hamming word; otherwise it is a DED.
    always_comb begin
        logic hit;
        hit     = 1'b0;
        corr    = bus.i_dout[ENCODED_WORD:1];
        dec_sec = 1'b0;
        dec_ded = 1'b0;
        if (syn == '0) begin
            dec_sec = p_all;               // only the overall parity bit flipped
        end else if (!p_all) begin
            dec_ded = 1'b1;
        end else begin
            for (int p = 1; p <= ENCODED_WORD; p++) begin
                if (syn == PARITY_BITS'(p)) begin
                    corr[p] = ~corr[p];
                    hit     = 1'b1;
                end
            end
            dec_sec = hit;
            dec_ded = !hit;
        end
    end

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_extract
        assign dec_data[i] = corr[data_pos(i)];
    end

    always_comb begin
        dec      = '0;
        dec.data = dec_data;
        dec.sec  = dec_sec;
        dec.ded  = dec_ded;
        dec.syn  = syn;
    end

    // Payload stages load only with a valid word, so the last stage holds
    // its result while o_valid is low.
    logic   [RD_LATENCY:1] vld_pipe;
    stage_t                pipe [1:RD_LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            for (int s = 1; s <= RD_LATENCY; s++) pipe[s] <= '0;
        end else begin
            vld_pipe[1] <= bus.i_valid;
            if (bus.i_valid) pipe[1] <= dec;
            for (int s = 2; s <= RD_LATENCY; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                if (vld_pipe[s-1]) pipe[s] <= pipe[s-1];
            end
        end
    end

    assign bus.o_valid    = vld_pipe[RD_LATENCY];
    assign bus.o_data     = pipe[RD_LATENCY].data;
    assign bus.o_sec      = pipe[RD_LATENCY].sec;
    assign bus.o_ded      = pipe[RD_LATENCY].ded;
    assign bus.o_syndrome = pipe[RD_LATENCY].syn;

`ifdef SECDED_ERR_CNT_EN
    logic [ADDR_WIDTH-1:0] addr_pipe [1:RD_LATENCY];
    logic [CNT_WIDTH-1:0]  sec_cnt;
    logic [CNT_WIDTH-1:0]  ded_cnt;
    logic [ADDR_WIDTH-1:0] ded_addr;
    logic                  ded_sticky;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 1; s <= RD_LATENCY; s++) addr_pipe[s] <= '0;
        end else begin
            if (bus.i_valid) addr_pipe[1] <= bus.i_addr;
            for (int s = 2; s <= RD_LATENCY; s++)
                if (vld_pipe[s-1]) addr_pipe[s] <= addr_pipe[s-1];
        end
    end

    // i_clr wins over any increment or capture in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_cnt    <= '0;
            ded_cnt    <= '0;
            ded_addr   <= '0;
            ded_sticky <= 1'b0;
        end else if (bus.i_clr) begin
            sec_cnt    <= '0;
            ded_cnt    <= '0;
            ded_addr   <= '0;
            ded_sticky <= 1'b0;
        end else begin
            if (bus.o_valid && bus.o_sec && sec_cnt != '1) sec_cnt <= sec_cnt + 1'b1;
            if (bus.o_valid && bus.o_ded && ded_cnt != '1) ded_cnt <= ded_cnt + 1'b1;
            if (bus.o_valid && bus.o_ded && !ded_sticky) begin
                ded_sticky <= 1'b1;
                ded_addr   <= addr_pipe[RD_LATENCY];
            end
        end
    end

    assign bus.o_sec_cnt    = sec_cnt;
    assign bus.o_ded_cnt    = ded_cnt;
    assign bus.o_ded_addr   = ded_addr;
    assign bus.o_ded_sticky = ded_sticky;
`else
    logic unused_cnt_inputs;
    assign unused_cnt_inputs = ^{bus.i_addr, bus.i_clr};

    assign bus.o_sec_cnt    = '0;
    assign bus.o_ded_cnt    = '0;
    assign bus.o_ded_addr   = '0;
    assign bus.o_ded_sticky = 1'b0;
`endif

endmodule
